mips_cpu_muldiv: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS CPU. It sits beside the combinational ALU on the execute path and is driven by the same decode/ALU-control stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It presents a start/busy/done handshake so the controller stalls while an operation is in flight; MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/mips_cpu_muldiv_if.sv | 14 +
 rtl/mips_cpu_muldiv.sv | 164 ++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_if.sv
// rtl/mips_cpu_muldiv_if.sv - start/busy/done handshake and HI/LO bus of the mul/div unit
interface mips_cpu_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv.sv
// rtl/mips_cpu_muldiv.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO
// Optional single-cycle multiply under MULDIV_FAST_MUL_EN.
module mips_cpu_muldiv (
  input  logic             clk,
  input  logic             reset_n,
  mips_cpu_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rsign_q, rsign_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, diff, sum;
  logic [63:0] prod;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] sprod, uprod;
  assign sprod = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign uprod = {32'd0, bus.a} * {32'd0, bus.b};
`endif

  assign signed_op = ~bus.op[0];
  assign a_mag     = (signed_op && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign b_mag     = (signed_op && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rsign_d  = rsign_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    shifted  = {rem_q, acc_q[31]};
    diff     = shifted - {1'b0, mcand_q};
    sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    prod     = neg_q ? (64'd0 - acc_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'b000, 3'b001: begin
              is_div_d = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
              neg_d    = 1'b0;
              acc_d    = signed_op ? sprod : uprod;
              state_d  = S_FIX;
`else
              neg_d    = signed_op & (bus.a[31] ^ bus.b[31]);
              mcand_d  = a_mag;
              acc_d    = {32'd0, b_mag};
              cnt_d    = 5'd31;
              state_d  = S_RUN;
`endif
            end
            3'b010, 3'b011: begin
              if (bus.b == 32'd0) begin
                // Reuse the multiply writeback: HI=a, LO=all ones, no sign fix.
                is_div_d = 1'b0;
                neg_d    = 1'b0;
                acc_d    = {bus.a, 32'hFFFF_FFFF};
                state_d  = S_FIX;
              end else begin
                is_div_d = 1'b1;
                neg_d    = signed_op & (bus.a[31] ^ bus.b[31]);
                rsign_d  = signed_op & bus.a[31];
                rem_d    = 32'd0;
                acc_d    = {32'd0, a_mag};
                mcand_d  = b_mag;
                cnt_d    = 5'd31;
                state_d  = S_RUN;
              end
            end
            3'b100:  hi_d = bus.a;
            3'b101:  lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          // Bit 32 of the trial difference set means the subtract underflowed: restore.
          if (!diff[32]) begin
            rem_d = diff[31:0];
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[31:0];
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {sum, acc_q[31:1]};
        end
        if (cnt_q == 5'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
          hi_d = rsign_q ? (32'd0 - rem_q) : rem_q;
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rsign_q  <= 1'b0;
      acc_q    <= 64'd0;
      mcand_q  <= 32'd0;
      rem_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rsign_q  <= rsign_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb/tb_mips_cpu_muldiv.sv - directed and random checks of mips_cpu_muldiv against an arithmetic model
module tb_mips_cpu_muldiv;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_cpu_muldiv_if bus ();
  mips_cpu_muldiv dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    if (op[1] && b == 32'd0) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) return 1;
`endif
    return 33;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    int n, busy_cnt, lat;
    logic [31:0] pre_hi, pre_lo;
    pre_hi = m_hi;
    pre_lo = m_lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    ref_model(op, a, b);
    if (op[2]) begin
      check("mt_busy", bus.busy, 0);
      check("mt_done", bus.done, 0);
      check("mt_hi", bus.hi, m_hi);
      check("mt_lo", bus.lo, m_lo);
      return;
    end
    lat = exp_lat(op, b);
    n = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (inject && n == 5) begin
        bus.start = 1'b1; bus.op = 3'b000; bus.a = $urandom; bus.b = $urandom;
      end
      if (n == 6) bus.start = 1'b0;
      if (n == 20) begin
        check("hold_hi", bus.hi, pre_hi);
        check("hold_lo", bus.lo, pre_lo);
      end
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("busy_cycles", busy_cnt, lat);
    check("busy_at_done", bus.busy, 0);
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    @(negedge clk);
    check("done_pulse", bus.done, 0);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    reset_n = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    reset_n = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    issue(3'd3, 32'h0000_1234, 32'd0, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'd0, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);

    // Back-to-back MTHI then MTLO on consecutive edges.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1111_2222;
    @(negedge clk);
    ref_model(3'd4, 32'h1111_2222, 32'd0);
    check("mthi_b2b", bus.hi, m_hi);
    bus.op = 3'd5; bus.a = 32'h3333_4444;
    @(negedge clk);
    bus.start = 1'b0;
    ref_model(3'd5, 32'h3333_4444, 32'd0);
    check("mtlo_b2b", bus.lo, m_lo);
    check("mt_b2b_busy", bus.busy, 0);
    check("mt_b2b_done", bus.done, 0);

    issue(3'd6, 32'h5555_5555, 32'd1, 1'b0);
    issue(3'd7, 32'h6666_6666, 32'd1, 1'b0);
    issue(3'd3, 32'hFFFF_0000, 32'd13, 1'b1);
    issue(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      issue(op, a, b, 1'b0);
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = $urandom; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    m_hi = 32'd0; m_lo = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", bus.done, 0);
    end
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_late_done", bus.done, 0);
    issue(3'd1, 32'd3, 32'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
